// File: rtl/jt12_slot_pkg.sv
// Shared slot-timing constants and the slot numbering used by every per-slot register group.
package jt12_slot_pkg;

  localparam int SLOTS  = 24;
  localparam int SLOT_W = 5;

  localparam int W_MUL   = 4;
  localparam int W_DT    = 3;
  localparam int W_MULDT = W_MUL + W_DT;
  localparam int W_TL    = 7;

  // Channels 0..2 sit in bank 0 and 3..5 in bank 1; each operator owns six consecutive slots.
  function automatic logic [SLOT_W-1:0] slot_enc(input logic [1:0] op, input logic [2:0] ch);
    return SLOT_W'(op) * SLOT_W'(6) + SLOT_W'(ch);
  endfunction

endpackage

// File: rtl/jt12_wr_fifo.sv
// Small in-order queue of pending CPU writes with a registered full flag.
module jt12_wr_fifo #(
  parameter  int DW    = 12,
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          rst,
  input  logic          clk,
  input  logic          push_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          pop_i,
  output logic [DW-1:0] rdata_o,
  output logic          empty_o,
  output logic          full_o,
  output logic [CW-1:0] count_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          full_q;
  logic          push_ok, pop_ok;

  function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign push_ok = push_i && !full_q;
  assign pop_ok  = pop_i && (cnt_q != '0);
  assign cnt_d   = cnt_q + CW'(push_ok) - CW'(pop_ok);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= ptr_next(wr_ptr_q);
      if (pop_ok)  rd_ptr_q <= ptr_next(rd_ptr_q);
      cnt_q  <= cnt_d;
      full_q <= (cnt_d == CW'(DEPTH));
    end
  end

  // NOTE: storage is deliberately not reset; the count alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign empty_o = (cnt_q == '0);
  assign full_o  = full_q;
  assign count_o = cnt_q;

endmodule

// File: rtl/jt12_slot_loader.sv
// Feeds the per-slot delay ring: recirculates ring_drop and splices queued CPU writes in at
// the target slot time. Owns the master slot counter.
module jt12_slot_loader
  import jt12_slot_pkg::*;
#(
  parameter int width  = 7,
  parameter int stages = 24,
  parameter int depth  = 2,
  parameter int rstval = 0
) (
  input  logic                   rst,
  input  logic                   clk,
  input  logic                   clk_en,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [SLOT_W-1:0]      wr_slot,
  input  logic [width-1:0]       wr_data,
  input  logic [width-1:0]       ring_drop,
  output logic [width-1:0]       ring_din,
  output logic [SLOT_W-1:0]      slot,
  output logic                   frame_zero,
  output logic [$clog2(depth):0] pending,
  output logic                   err_bad_slot
);

  if (stages < 3 || stages > (1 << SLOT_W) || depth < 1 || (depth & (depth - 1)) != 0
      || rstval < 0) begin : g_bad_params
    $error("jt12_slot_loader: illegal parameter set");
  end

  logic [SLOT_W-1:0]       slot_q, slot_d;
  logic                    err_q, err_d;
  logic                    accept, push, hit;
  logic                    fifo_empty, fifo_full;
  logic [SLOT_W+width-1:0] head_entry;
  logic [SLOT_W-1:0]       head_slot;
  logic [width-1:0]        head_data;

  assign wr_ready = !fifo_full;
  assign accept   = wr_valid && wr_ready;
  assign push     = accept && (int'(wr_slot) < stages);

  assign head_slot = head_entry[SLOT_W+width-1:width];
  assign head_data = head_entry[width-1:0];

  // Only the queue head is ever compared, which keeps commits strictly in order.
  assign hit      = !fifo_empty && clk_en && (head_slot == slot_q);
  assign ring_din = hit ? head_data : ring_drop;

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    slot_d = slot_q;
    if (clk_en) slot_d = (slot_q == SLOT_W'(stages - 1)) ? '0 : slot_q + 1'b1;
    err_d = err_q | (accept && !push);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q <= '0;
      err_q  <= 1'b0;
    end else begin
      slot_q <= slot_d;
      err_q  <= err_d;
    end
  end

  jt12_wr_fifo #(
    .DW    (SLOT_W + width),
    .DEPTH (depth)
  ) u_fifo (
    .rst     (rst),
    .clk     (clk),
    .push_i  (push),
    .wdata_i ({wr_slot, wr_data}),
    .pop_i   (hit),
    .rdata_o (head_entry),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .count_o (pending)
  );

  assign slot         = slot_q;
  assign frame_zero   = (slot_q == '0);
  assign err_bad_slot = err_q;

endmodule

// File: tb/tb_jt12_slot_loader.sv
// Drives jt12_slot_loader against a 24-slot ring model and a queue-based reference of the
// expected ring contents, slot time and pending writes.
module tb_jt12_slot_loader;
  import jt12_slot_pkg::*;

  localparam int W     = 7;
  localparam int ST    = 24;
  localparam int DEPTH = 2;

  logic       rst, clk, clk_en, wr_valid, wr_ready, frame_zero, err_bad_slot;
  logic [4:0] wr_slot, slot;
  logic [W-1:0] wr_data, ring_drop, ring_din;
  logic [1:0] pending;

  int total = 0;
  int bad   = 0;

  jt12_slot_loader #(.width(W), .stages(ST), .depth(DEPTH), .rstval(0)) dut (
    .rst          (rst),
    .clk          (clk),
    .clk_en       (clk_en),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_slot      (wr_slot),
    .wr_data      (wr_data),
    .ring_drop    (ring_drop),
    .ring_din     (ring_din),
    .slot         (slot),
    .frame_zero   (frame_zero),
    .pending      (pending),
    .err_bad_slot (err_bad_slot)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment: the delay ring itself, addressed by the slot the DUT reports.
  logic [W-1:0] ring [ST];
  bit preload = 1'b1;
  assign ring_drop = ring[slot];
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < ST; i++) ring[i] <= W'(i);
    end else if (clk_en) begin
      ring[slot] <= ring_din;
    end
  end

  // Reference model: what the ring should hold, the current slot and the pending writes.
  typedef struct packed {
    logic [4:0]   s;
    logic [W-1:0] d;
  } wr_t;

  typedef struct {
    int           slot;
    bit           fz;
    int           pend;
    bit           rdy;
    logic [W-1:0] din;
    logic [W-1:0] drop;
    bit           err;
    bit           acc;
  } exp_t;

  wr_t          q[$];
  int           m_slot;
  bit           m_err;
  logic [W-1:0] m_ring [ST];

  task automatic model_reset();
    q.delete();
    m_slot = 0;
    m_err  = 1'b0;
  endtask

  // Applies one cycle of stimulus, returns what the DUT must show before the edge, then
  // advances the model past the edge.
  task automatic step(input bit en, input bit v, input logic [4:0] s, input logic [W-1:0] d,
                      output exp_t e);
    bit hit;
    @(negedge clk);
    clk_en = en; wr_valid = v; wr_slot = s; wr_data = d;
    #1;
    e.slot = m_slot;
    e.fz   = (m_slot == 0);
    e.pend = q.size();
    e.rdy  = (q.size() < DEPTH);
    e.err  = m_err;
    e.drop = m_ring[m_slot];
    hit    = en && (q.size() != 0) && (int'(q[0].s) == m_slot);
    e.din  = hit ? q[0].d : m_ring[m_slot];
    e.acc  = v && e.rdy;
    if (en) m_ring[m_slot] = e.din;
    if (hit) void'(q.pop_front());
    if (e.acc) begin
      if (int'(s) < ST) q.push_back('{s: s, d: d});
      else m_err = 1'b1;
    end
    if (en) m_slot = (m_slot + 1) % ST;
  endtask

  task automatic idle_until(input int target);
    exp_t e;
    for (int n = 0; n < 3 * ST && m_slot != target; n++) step(1'b1, 1'b0, 5'd0, '0, e);
  endtask

  task automatic drain();
    exp_t e;
    for (int n = 0; n < 4 * ST && q.size() != 0; n++) step(1'b1, 1'b0, 5'd0, '0, e);
  endtask

  task automatic test_reset();
    rst = 1'b1; clk_en = 1'b0; wr_valid = 1'b0; wr_slot = '0; wr_data = '0;
    for (int i = 0; i < ST; i++) m_ring[i] = W'(i);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    total += 6;
    if (slot !== 5'd0) begin bad++; $display("FAIL reset_slot got=%0d exp=0", slot); end
    if (pending !== 2'd0) begin bad++; $display("FAIL reset_pending got=%0d exp=0", pending); end
    if (wr_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", wr_ready); end
    if (err_bad_slot !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err_bad_slot); end
    if (frame_zero !== 1'b1) begin bad++; $display("FAIL reset_fz got=%b exp=1", frame_zero); end
    if (ring_din !== ring_drop) begin
      bad++; $display("FAIL reset_passthru din=%h drop=%h", ring_din, ring_drop);
    end
    rst = 1'b0; preload = 1'b0;
  endtask

  task automatic test_passthrough();
    exp_t e;
    for (int c = 0; c < 2 * ST; c++) begin
      step(1'b1, 1'b0, 5'd0, '0, e);
      total += 4;
      if (ring_din !== W'(c % ST)) begin
        bad++; $display("FAIL pass_din cyc=%0d got=%h exp=%h", c, ring_din, W'(c % ST));
      end
      if (slot !== 5'(e.slot)) begin bad++; $display("FAIL pass_slot got=%0d exp=%0d", slot, e.slot); end
      if (frame_zero !== e.fz) begin
        bad++; $display("FAIL pass_fz cyc=%0d got=%b exp=%b", c, frame_zero, e.fz);
      end
      if (pending !== 2'd0) begin bad++; $display("FAIL pass_pending got=%0d exp=0", pending); end
    end
  endtask

  task automatic test_single();
    exp_t e;
    idle_until(2);
    step(1'b1, 1'b1, 5'd5, 7'h2A, e);
    for (int c = 0; c < ST + 6; c++) begin
      step(1'b1, 1'b0, 5'd0, '0, e);
      total += 3;
      if (ring_din !== e.din) begin
        bad++; $display("FAIL single_din slot=%0d got=%h exp=%h", e.slot, ring_din, e.din);
      end
      if (ring_drop !== e.drop) begin
        bad++; $display("FAIL single_drop slot=%0d got=%h exp=%h", e.slot, ring_drop, e.drop);
      end
      if (pending !== 2'(e.pend)) begin
        bad++; $display("FAIL single_pending got=%0d exp=%0d", pending, e.pend);
      end
    end
  endtask

  task automatic test_order();
    exp_t e;
    drain();
    idle_until(4);
    step(1'b0, 1'b1, 5'd10, 7'h11, e);
    step(1'b0, 1'b1, 5'd3, 7'h33, e);
    for (int c = 0; c < 2 * ST; c++) begin
      step(1'b1, 1'b0, 5'd0, '0, e);
      total += 3;
      if (ring_din !== e.din) begin
        bad++; $display("FAIL order_din slot=%0d got=%h exp=%h", e.slot, ring_din, e.din);
      end
      if (ring_drop !== e.drop) begin
        bad++; $display("FAIL order_drop slot=%0d got=%h exp=%h", e.slot, ring_drop, e.drop);
      end
      if (pending !== 2'(e.pend)) begin
        bad++; $display("FAIL order_pending got=%0d exp=%0d", pending, e.pend);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t         e;
    int           idx;
    logic [4:0]   ts [3];
    logic [W-1:0] td [3];
    drain();
    idle_until(6);
    ts[0] = slot_enc(2'd1, 3'd2); ts[1] = slot_enc(2'd1, 3'd3); ts[2] = slot_enc(2'd2, 3'd0);
    td[0] = 7'h51; td[1] = 7'h62; td[2] = 7'h73;
    idx = 0;
    for (int c = 0; c < 60 && idx < 3; c++) begin
      step(1'b1, 1'b1, ts[idx], td[idx], e);
      total += 3;
      if (wr_ready !== e.rdy) begin
        bad++; $display("FAIL b2b_ready cyc=%0d got=%b exp=%b", c, wr_ready, e.rdy);
      end
      if (ring_din !== e.din) begin
        bad++; $display("FAIL b2b_din slot=%0d got=%h exp=%h", e.slot, ring_din, e.din);
      end
      if (pending !== 2'(e.pend)) begin
        bad++; $display("FAIL b2b_pending got=%0d exp=%0d", pending, e.pend);
      end
      if (e.acc) idx++;
    end
    total++;
    if (idx != 3) begin bad++; $display("FAIL b2b_timeout accepted=%0d exp=3", idx); end
    for (int c = 0; c < ST + 4; c++) begin
      step(1'b1, 1'b0, 5'd0, '0, e);
      total += 2;
      if (ring_din !== e.din) begin
        bad++; $display("FAIL b2b_land_din slot=%0d got=%h exp=%h", e.slot, ring_din, e.din);
      end
      if (ring_drop !== e.drop) begin
        bad++; $display("FAIL b2b_land_drop slot=%0d got=%h exp=%h", e.slot, ring_drop, e.drop);
      end
    end
  endtask

  task automatic test_random();
    exp_t e;
    for (int c = 0; c < 400; c++) begin
      step(($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1, 5'($urandom_range(0, ST - 1)),
           W'($urandom), e);
      total += 6;
      if (ring_din !== e.din) begin
        bad++; $display("FAIL rnd_din cyc=%0d got=%h exp=%h", c, ring_din, e.din);
      end
      if (ring_drop !== e.drop) begin
        bad++; $display("FAIL rnd_drop cyc=%0d got=%h exp=%h", c, ring_drop, e.drop);
      end
      if (slot !== 5'(e.slot)) begin bad++; $display("FAIL rnd_slot got=%0d exp=%0d", slot, e.slot); end
      if (wr_ready !== e.rdy) begin bad++; $display("FAIL rnd_ready got=%b exp=%b", wr_ready, e.rdy); end
      if (pending !== 2'(e.pend)) begin
        bad++; $display("FAIL rnd_pending got=%0d exp=%0d", pending, e.pend);
      end
      if (err_bad_slot !== e.err) begin
        bad++; $display("FAIL rnd_err got=%b exp=%b", err_bad_slot, e.err);
      end
    end
  endtask

  task automatic test_bad_slot();
    exp_t e;
    drain();
    step(1'b1, 1'b1, 5'd30, 7'h7F, e);
    for (int c = 0; c < ST + 1; c++) begin
      step(1'b1, 1'b0, 5'd0, '0, e);
      total += 3;
      if (err_bad_slot !== 1'b1) begin bad++; $display("FAIL bad_err got=%b exp=1", err_bad_slot); end
      if (pending !== 2'd0) begin bad++; $display("FAIL bad_pending got=%0d exp=0", pending); end
      if (ring_drop !== e.drop) begin
        bad++; $display("FAIL bad_ring slot=%0d got=%h exp=%h", e.slot, ring_drop, e.drop);
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    drain();
    idle_until(10);
    step(1'b1, 1'b1, 5'd20, 7'h55, e);
    idle_until(12);
    @(negedge clk);
    clk_en = 1'b0; wr_valid = 1'b0; rst = 1'b1;
    #1;
    model_reset();
    total += 4;
    if (slot !== 5'd0) begin bad++; $display("FAIL rmid_slot got=%0d exp=0", slot); end
    if (pending !== 2'd0) begin bad++; $display("FAIL rmid_pending got=%0d exp=0", pending); end
    if (wr_ready !== 1'b1) begin bad++; $display("FAIL rmid_ready got=%b exp=1", wr_ready); end
    if (err_bad_slot !== 1'b0) begin bad++; $display("FAIL rmid_err got=%b exp=0", err_bad_slot); end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < ST + 4; c++) begin
      step(1'b1, 1'b0, 5'd0, '0, e);
      total += 2;
      if (ring_din !== e.din) begin
        bad++; $display("FAIL rmid_din slot=%0d got=%h exp=%h", e.slot, ring_din, e.din);
      end
      if (ring_drop !== e.drop) begin
        bad++; $display("FAIL rmid_drop slot=%0d got=%h exp=%h", e.slot, ring_drop, e.drop);
      end
    end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_single();
    test_order();
    test_back_to_back();
    test_random();
    test_bad_slot();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
